dllp_rx_assembler: RTL and testbench
====================================

Name: dllp_rx_assembler

Overview:
- Sits directly downstream of the receive packet identifier. Consumes its byte-lane data bus and the per-byte type flags: valid, dlpstart, dlpend.
- Reassembles 6-byte DLLPs, which may be split across cycles, into whole 48-bit words.
- Length-checks each DLLP and queues it in a small FIFO. The FIFO drains to the data link layer over a valid/ready handshake.
- TLP-flagged bytes are ignored here. They are handled by a sibling TLP path.

Parameters:
- NBYTES, 8, number of byte lanes processed per cycle. Lanes 0..NBYTES-1 of the 512-bit bus are used. Legal values are 1..8.
- FIFO_DEPTH, 4, number of assembled-DLLP entries. Must be a power of 2, minimum 2.
- DLLP_LEN, 6, required DLLP content length in bytes.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- data_in  in  512  byte lanes; lane i is bits [8i+7:8i].
- pl_valid  in  64  per-lane content-byte valid.
- pl_dlpstart  in  64  per-lane: first byte of a DLLP.
- pl_dlpend  in  64  per-lane: last byte of a DLLP.
- linkup  in  1  link up. When low, the block flushes.
- dllp_data  out  48  head DLLP; byte 0 is in [47:40].
- dllp_valid  out  1  head entry available.
- dllp_ready  in  1  consumer accepts the head entry.
- err_len  out  1  one-cycle pulse: a DLLP was dropped for bad length or framing.
- err_ovf  out  1  one-cycle pulse: a DLLP was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset values: assembly state IDLE, byte count 0, FIFO empty, dllp_valid=0, dllp_data=0, err_len=0, err_ovf=0, fifo_level=0.
- Assembly state machine has two states, IDLE and COLLECT. Lanes are scanned 0 to NBYTES-1 within a cycle. Only lanes with pl_valid=1 participate; others are ignored entirely.
- Byte with dlpstart:
  - Load it as byte 0, set count=1, go to COLLECT.
  - If already in COLLECT, the partial DLLP is discarded, err_len pulses, and the new DLLP starts.
- Byte in COLLECT without start: append at position count, then count++.
  - If count would exceed DLLP_LEN, discard, pulse err_len, go to IDLE.
- Byte with dlpend:
  - After appending, if count==DLLP_LEN, the DLLP is complete: push to FIFO, go to IDLE.
  - Otherwise discard, pulse err_len, go to IDLE.
- A byte carrying both start and end forms a 1-byte DLLP, which is a length error.
- Non-start valid bytes in IDLE are discarded silently; they are TLP or idle bytes.
- At most one DLLP completion per cycle is supported.
  - A second dlpend in the same cycle drops that DLLP and pulses err_len.
  - Multiple error causes in one cycle still produce a single err_len pulse.
- Push latency: a DLLP whose end byte arrives in cycle N is visible at dllp_data/dllp_valid in cycle N+1 if the FIFO was empty.
- FIFO:
  - Pop occurs when dllp_valid && dllp_ready.
  - A simultaneous push and pop when full succeeds: the pop frees the slot.
  - A push when full without a pop drops the new DLLP, pulses err_ovf, and leaves contents unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - dllp_data is held stable while dllp_valid=1 and dllp_ready=0.
  - dllp_data shows the head entry; it is 0 when empty.
- linkup=0: synchronously clear assembly state and FIFO on the next edge, identical to reset. No error pulses. Inputs are ignored while linkup=0.
- Asynchronous reset mid-packet discards the partial DLLP and all queued entries immediately.
- fifo_level updates on the same edge as push/pop.

Test Plan:
- Single DLLP in one cycle: lanes 1..6 = 00 11 22 33 44 55, start on lane 1, end on lane 6, ready=1 → next cycle dllp_valid=1, dllp_data=48'h001122334455, no errors.
- Split DLLP: bytes AA BB BC in lanes 5..7 with start at lane 5; next cycle CC DD EE in lanes 0..2 with end at lane 2 → dllp_data=48'hAABBBCCCDDEE one cycle after the end.
- Short DLLP: start then end after 4 bytes → err_len pulses 1 cycle, FIFO unchanged; a following valid 6-byte DLLP is accepted.
- Restart: start plus 3 bytes, then a new start plus a full 6-byte DLLP → err_len once, only the second DLLP is queued.
- Backpressure: ready=0, push 5 DLLPs with FIFO_DEPTH=4 → fifo_level=4, err_ovf pulses on the 5th push, then ready=1 drains the first 4 in order. A push+pop while full is accepted with no err_ovf.
- Flush: 3 queued entries plus a partial DLLP, linkup=0 for 1 cycle → fifo_level=0, dllp_valid=0, no error pulses. Repeat using asynchronous reset asserted mid-cycle → outputs clear immediately.

Source files
------------

// File: rtl/dllp_rx_assembler_if.sv
// Byte-lane input bus from the packet identifier plus the DLLP valid/ready output stream.
interface dllp_rx_assembler_if;
    logic [511:0] data_in;
    logic [63:0]  pl_valid;
    logic [63:0]  pl_dlpstart;
    logic [63:0]  pl_dlpend;
    logic [47:0]  dllp_data;
    logic         dllp_valid;
    logic         dllp_ready;

    // Environment side: drives lanes and accepts DLLPs.
    modport master (
        output data_in, pl_valid, pl_dlpstart, pl_dlpend, dllp_ready,
        input  dllp_data, dllp_valid
    );

    // Assembler side: consumes lanes and presents DLLPs.
    modport slave (
        input  data_in, pl_valid, pl_dlpstart, pl_dlpend, dllp_ready,
        output dllp_data, dllp_valid
    );
endinterface

// File: rtl/dllp_rx_assembler.sv
// Reassembles framed DLLP bytes from the receive byte lanes, length-checks
// each one and queues complete DLLPs in a small FIFO for the link layer.
module dllp_rx_assembler #(
    parameter int unsigned NBYTES     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DLLP_LEN   = 6
) (
    input  logic                          clk,
    input  logic                          reset,
    dllp_rx_assembler_if.slave            bus,
    input  logic                          linkup,
    output logic                          err_len,
    output logic                          err_ovf,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned CW        = $clog2(DLLP_LEN + 1);
    localparam int unsigned PW        = $clog2(FIFO_DEPTH);
    localparam int unsigned LW        = PW + 1;
    localparam int unsigned BUF_BYTES = 6;
    localparam int unsigned DW        = BUF_BYTES * 8;

    typedef enum logic {IDLE, COLLECT} state_t;

    state_t          state_q, state_nx;
    logic [CW-1:0]   cnt_q, cnt_nx;
    logic [DW-1:0]   asm_q, asm_nx;
    logic [7:0]      lane_byte;
    logic            push_c;
    logic [DW-1:0]   push_data_c;
    logic            len_err_c;

    logic [DW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic            pop_c, full_c, do_push_c, ovf_c;
    logic [LW-1:0]   level_nx, remain_c;
    logic [DW-1:0]   head_nx;
    logic [DW-1:0]   dllp_data_q;
    logic            dllp_valid_q;

    // Upper lanes are outside this configuration and deliberately ignored.
    logic unused_hi;
    assign unused_hi = ^{bus.data_in[511:8*NBYTES], bus.pl_valid[63:NBYTES],
                         bus.pl_dlpstart[63:NBYTES], bus.pl_dlpend[63:NBYTES]};

    assign bus.dllp_data  = dllp_data_q;
    assign bus.dllp_valid = dllp_valid_q;

    // Assembly state register; a link-down cycle flushes like reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else if (!linkup) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            asm_q   <= '0;
        end else begin
            state_q <= state_nx;
            cnt_q   <= cnt_nx;
            asm_q   <= asm_nx;
        end
    end

    // Lane scan 0..NBYTES-1: start/append/end handling, one completion per cycle.
    always_comb begin
        state_nx    = state_q;
        cnt_nx      = cnt_q;
        asm_nx      = asm_q;
        lane_byte   = '0;
        push_c      = 1'b0;
        push_data_c = '0;
        len_err_c   = 1'b0;
        if (linkup) begin
            for (int i = 0; i < int'(NBYTES); i++) begin
                if (bus.pl_valid[i]) begin
                    lane_byte = bus.data_in[8*i +: 8];
                    if (bus.pl_dlpstart[i]) begin
                        if (state_nx == COLLECT) begin
                            len_err_c = 1'b1;
                        end
                        asm_nx          = '0;
                        asm_nx[DW-1 -: 8] = lane_byte;
                        cnt_nx          = CW'(1);
                        state_nx        = COLLECT;
                    end else if (state_nx == COLLECT) begin
                        if (cnt_nx >= CW'(DLLP_LEN)) begin
                            len_err_c = 1'b1;
                            state_nx  = IDLE;
                            cnt_nx    = '0;
                        end else begin
                            asm_nx[8*(int'(BUF_BYTES)-1-int'(cnt_nx)) +: 8] = lane_byte;
                            cnt_nx = cnt_nx + CW'(1);
                        end
                    end
                    if (bus.pl_dlpend[i] && (state_nx == COLLECT)) begin
                        if ((cnt_nx == CW'(DLLP_LEN)) && !push_c) begin
                            push_c      = 1'b1;
                            push_data_c = asm_nx;
                        end else begin
                            len_err_c = 1'b1;
                        end
                        state_nx = IDLE;
                        cnt_nx   = '0;
                    end
                end
            end
        end
    end

    // FIFO control: pop/push/overflow decisions and the next head word.
    always_comb begin
        pop_c     = dllp_valid_q && bus.dllp_ready && linkup;
        full_c    = (fifo_level == LW'(FIFO_DEPTH));
        do_push_c = push_c && (!full_c || pop_c);
        ovf_c     = push_c && full_c && !pop_c;
        unique case ({do_push_c, pop_c})
            2'b10:   level_nx = fifo_level + LW'(1);
            2'b01:   level_nx = fifo_level - LW'(1);
            default: level_nx = fifo_level;
        endcase
        remain_c = fifo_level - LW'(pop_c);
        if (remain_c != '0) begin
            head_nx = mem[rd_ptr + PW'(pop_c)];
        end else if (do_push_c) begin
            head_nx = push_data_c;
        end else begin
            head_nx = '0;
        end
    end

    // FIFO storage; stale entries are never visible so no reset is needed.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= push_data_c;
        end
    end

    // FIFO pointers, occupancy, registered head and error pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            dllp_data_q  <= '0;
            dllp_valid_q <= 1'b0;
            err_len      <= 1'b0;
            err_ovf      <= 1'b0;
        end else if (!linkup) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            dllp_data_q  <= '0;
            dllp_valid_q <= 1'b0;
            err_len      <= 1'b0;
            err_ovf      <= 1'b0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_level   <= level_nx;
            dllp_data_q  <= head_nx;
            dllp_valid_q <= (level_nx != '0);
            err_len      <= len_err_c;
            err_ovf      <= ovf_c;
        end
    end

endmodule

// File: tb/tb_dllp_rx_assembler.sv
// Randomized and directed bench for dllp_rx_assembler with a queue-based reference model.
module tb_dllp_rx_assembler;

    localparam int NB    = 8;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       linkup;
    logic       err_len;
    logic       err_ovf;
    logic [2:0] fifo_level;

    dllp_rx_assembler_if bus();

    dllp_rx_assembler #(.NBYTES(NB), .FIFO_DEPTH(DEPTH), .DLLP_LEN(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .linkup     (linkup),
        .err_len    (err_len),
        .err_ovf    (err_ovf),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: in-flight byte list and queue of whole DLLPs.
    bit          in_pkt;
    logic [7:0]  cur [$];
    logic [47:0] q   [$];
    bit          exp_len;
    bit          exp_ovf;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic model_clear();
        in_pkt  = 1'b0;
        cur.delete();
        q.delete();
        exp_len = 1'b0;
        exp_ovf = 1'b0;
    endtask

    // Apply the framing rules to the bytes presented this cycle.
    task automatic model_step();
        bit          popped;
        bit          have;
        bit          err;
        logic [47:0] pkt;
        logic [7:0]  b;
        if (reset || !linkup) begin
            model_clear();
            return;
        end
        popped = (q.size() > 0) && bus.dllp_ready;
        have   = 1'b0;
        err    = 1'b0;
        pkt    = '0;
        for (int i = 0; i < NB; i++) begin
            if (bus.pl_valid[i]) begin
                b = bus.data_in[8*i +: 8];
                if (bus.pl_dlpstart[i]) begin
                    if (in_pkt) err = 1'b1;
                    cur.delete();
                    cur.push_back(b);
                    in_pkt = 1'b1;
                end else if (in_pkt) begin
                    if (cur.size() == 6) begin
                        err    = 1'b1;
                        in_pkt = 1'b0;
                        cur.delete();
                    end else begin
                        cur.push_back(b);
                    end
                end
                if (bus.pl_dlpend[i] && in_pkt) begin
                    if (cur.size() == 6 && !have) begin
                        have = 1'b1;
                        pkt  = '0;
                        foreach (cur[k]) pkt = {pkt[39:0], cur[k]};
                    end else begin
                        err = 1'b1;
                    end
                    in_pkt = 1'b0;
                    cur.delete();
                end
            end
        end
        if (popped) void'(q.pop_front());
        exp_ovf = 1'b0;
        if (have) begin
            if (q.size() < DEPTH) q.push_back(pkt);
            else                  exp_ovf = 1'b1;
        end
        exp_len = err;
    endtask

    task automatic compare_all();
        check("dllp_valid", 64'(bus.dllp_valid), 64'(q.size() > 0));
        check("dllp_data",  64'(bus.dllp_data),  64'((q.size() > 0) ? q[0] : 48'h0));
        check("fifo_level", 64'(fifo_level),     64'(q.size()));
        check("err_len",    64'(err_len),        64'(exp_len));
        check("err_ovf",    64'(err_ovf),        64'(exp_ovf));
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_lanes();
        bus.data_in     = '0;
        bus.pl_valid    = '0;
        bus.pl_dlpstart = '0;
        bus.pl_dlpend   = '0;
    endtask

    task automatic set_lane(input int i, input logic [7:0] b, input logic s, input logic e);
        bus.data_in[8*i +: 8] = b;
        bus.pl_valid[i]       = 1'b1;
        bus.pl_dlpstart[i]    = s;
        bus.pl_dlpend[i]      = e;
    endtask

    // Whole 6-byte DLLP on lanes 0..5 with bytes base, base+1, ...
    task automatic put_dllp(input logic [7:0] base);
        clear_lanes();
        for (int k = 0; k < 6; k++) set_lane(k, base + 8'(k), k == 0, k == 5);
    endtask

    task automatic put_partial();
        clear_lanes();
        set_lane(5, 8'h71, 1'b1, 1'b0);
        set_lane(6, 8'h72, 1'b0, 1'b0);
    endtask

    int rem = 0;

    // Random lane traffic: mostly well-formed DLLPs, some bad lengths and restarts.
    task automatic random_lanes();
        logic s;
        logic e;
        int   len;
        clear_lanes();
        for (int i = 0; i < NB; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                s = 1'b0;
                e = 1'b0;
                if (rem == 0) begin
                    if ($urandom_range(0, 1) == 1) begin
                        s   = 1'b1;
                        len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 8)) : 6;
                        rem = len - 1;
                        e   = (rem == 0);
                    end
                end else if ($urandom_range(0, 31) == 0) begin
                    s   = 1'b1;
                    rem = 5;
                end else begin
                    rem = rem - 1;
                    e   = (rem == 0);
                end
                set_lane(i, 8'($urandom), s, e);
            end else begin
                bus.data_in[8*i +: 8] = 8'($urandom);
                bus.pl_dlpstart[i]    = 1'($urandom);
                bus.pl_dlpend[i]      = 1'($urandom);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        linkup = 1'b1;
        bus.dllp_ready = 1'b0;
        clear_lanes();
        model_clear();
        tick();
        check("rst_level", 64'(fifo_level), 64'd0);
        check("rst_data",  64'(bus.dllp_data), 64'd0);
        reset = 1'b0;
        tick();

        // Single DLLP on lanes 1..6.
        clear_lanes();
        for (int k = 0; k < 6; k++) set_lane(k + 1, 8'(8'h11 * k), k == 0, k == 5);
        bus.dllp_ready = 1'b1;
        tick();
        check("single_data",  64'(bus.dllp_data), 64'h001122334455);
        check("single_valid", 64'(bus.dllp_valid), 64'd1);
        clear_lanes();
        tick();

        // DLLP split across two cycles.
        bus.dllp_ready = 1'b0;
        clear_lanes();
        set_lane(5, 8'hAA, 1'b1, 1'b0);
        set_lane(6, 8'hBB, 1'b0, 1'b0);
        set_lane(7, 8'hBC, 1'b0, 1'b0);
        tick();
        clear_lanes();
        set_lane(0, 8'hCC, 1'b0, 1'b0);
        set_lane(1, 8'hDD, 1'b0, 1'b0);
        set_lane(2, 8'hEE, 1'b0, 1'b1);
        tick();
        check("split_data", 64'(bus.dllp_data), 64'hAABBBCCCDDEE);
        clear_lanes();
        bus.dllp_ready = 1'b1;
        tick();

        // Short DLLP then a good one.
        clear_lanes();
        for (int k = 0; k < 4; k++) set_lane(k, 8'h50 + 8'(k), k == 0, k == 3);
        tick();
        check("short_err", 64'(err_len), 64'd1);
        put_dllp(8'h60);
        tick();
        check("short_next_err", 64'(err_len), 64'd0);
        clear_lanes();
        tick();

        // Restart: partial then a fresh full DLLP straddling two cycles.
        clear_lanes();
        for (int k = 0; k < 4; k++) set_lane(k, 8'h80 + 8'(k), k == 0, 1'b0);
        for (int k = 0; k < 4; k++) set_lane(k + 4, 8'h90 + 8'(k), k == 0, 1'b0);
        tick();
        check("restart_err", 64'(err_len), 64'd1);
        clear_lanes();
        set_lane(0, 8'h94, 1'b0, 1'b0);
        set_lane(1, 8'h95, 1'b0, 1'b1);
        tick();
        check("restart_data", 64'(bus.dllp_data), 64'h909192939495);
        clear_lanes();
        tick();

        // Backpressure: five pushes into a depth-4 FIFO, then push+pop while full.
        bus.dllp_ready = 1'b0;
        for (int n = 0; n < 5; n++) begin
            put_dllp(8'(8'h10 * (n + 1)));
            tick();
        end
        check("bp_level", 64'(fifo_level), 64'd4);
        check("bp_ovf",   64'(err_ovf),    64'd1);
        put_dllp(8'hA0);
        bus.dllp_ready = 1'b1;
        tick();
        check("bp_pushpop_ovf", 64'(err_ovf), 64'd0);
        check("bp_pushpop_head", 64'(bus.dllp_data), 64'h202122232425);
        clear_lanes();
        for (int n = 0; n < 5; n++) tick();

        // Flush via linkup with three entries and a partial in flight.
        bus.dllp_ready = 1'b0;
        for (int n = 0; n < 3; n++) begin
            put_dllp(8'(8'h30 + 8'h08 * n));
            tick();
        end
        put_partial();
        tick();
        linkup = 1'b0;
        put_dllp(8'hC0);
        tick();
        check("flush_level", 64'(fifo_level), 64'd0);
        linkup = 1'b1;
        clear_lanes();
        tick();

        // Flush via asynchronous reset asserted between edges.
        for (int n = 0; n < 3; n++) begin
            put_dllp(8'(8'h40 + 8'h08 * n));
            tick();
        end
        put_partial();
        tick();
        reset = 1'b1;
        #1;
        model_clear();
        compare_all();
        check("areset_level", 64'(fifo_level), 64'd0);
        tick();
        reset = 1'b0;
        clear_lanes();
        tick();

        // Random traffic with random backpressure and occasional link drops.
        for (int c = 0; c < 3000; c++) begin
            random_lanes();
            bus.dllp_ready = ($urandom_range(0, 3) != 0);
            linkup = ($urandom_range(0, 199) != 0);
            tick();
        end
        linkup = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
